// File: rtl/mem_arbiter_if.sv
// Bundle of the requester handshakes (IF fetch, MEM load/store) and the memory-macro bus
// seen by the unified-memory arbiter. The slave view is the arbiter; the master view is its environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-3:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_enable;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;
  logic              mem_ack;

  logic              stall_pipeline;
  logic              bus_error;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_out, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_enable, mem_read, mem_write, mem_address, mem_in,
           stall_pipeline, bus_error
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_out, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_enable, mem_read, mem_write, mem_address, mem_in,
           stall_pipeline, bus_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory macro between instruction fetch and
// load/store, with DM-streak fairness, an access timeout and a sticky bus error.
module mem_arbiter #(
  parameter int                ADDR_W        = 12,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] IM_BASE       = 12'hC00,
  parameter int                MAX_DM_STREAK = 4,
  parameter int                TIMEOUT       = 15
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam int                    STREAK_W   = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
  localparam logic [3:0]            TMO_LAST   = 4'(TIMEOUT - 1);

  state_t              state;
  state_t              state_d;
  logic [STREAK_W-1:0] dm_streak;
  logic [3:0]          tmo_cnt;
  logic                grant_if;
  logic                grant_dm;
  logic                done;
  logic                abort;
  logic                ready_pulse;

  assign bus.stall_pipeline = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // No grant while a ready pulse is showing: the requester's req is still the stale one
  // of the access just finished, and skipping that cycle keeps the streak count honest.
  always_comb begin
    state_d     = state;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    ready_pulse = bus.if_ready | bus.dm_ready;
    case (state)
      IDLE: begin
        if (!ready_pulse) begin
          if (bus.if_req && (!bus.dm_req || dm_streak == STREAK_MAX)) begin
            grant_if = 1'b1;
            state_d  = BUSY_IF;
          end else if (bus.dm_req) begin
            grant_dm = 1'b1;
            state_d  = BUSY_DM;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.if_rdata    <= '0;
      bus.if_ready    <= 1'b0;
      bus.dm_rdata    <= '0;
      bus.dm_ready    <= 1'b0;
      bus.mem_enable  <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_in      <= '0;
      bus.bus_error   <= 1'b0;
      dm_streak       <= '0;
      tmo_cnt         <= '0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;

      if (grant_if) begin
        bus.mem_address <= IM_BASE | {2'b00, bus.if_addr};
        bus.mem_read    <= 1'b1;
        bus.mem_write   <= 1'b0;
        bus.mem_enable  <= 1'b1;
      end else if (grant_dm) begin
        bus.mem_address <= bus.dm_addr;
        bus.mem_in      <= bus.dm_wdata;
        bus.mem_read    <= ~bus.dm_we;
        bus.mem_write   <= bus.dm_we;
        bus.mem_enable  <= 1'b1;
      end

      if (grant_if || grant_dm) tmo_cnt <= '0;
      else if (state != IDLE)   tmo_cnt <= tmo_cnt + 4'd1;

      // Completion or abort: one ready pulse to the owner; an abort returns zero data.
      if (done || abort) begin
        bus.mem_enable <= 1'b0;
        bus.mem_read   <= 1'b0;
        bus.mem_write  <= 1'b0;
        if (state == BUSY_IF) begin
          bus.if_ready <= 1'b1;
          bus.if_rdata <= done ? bus.mem_out : '0;
        end else begin
          bus.dm_ready <= 1'b1;
          if (abort)             bus.dm_rdata <= '0;
          else if (bus.mem_read) bus.dm_rdata <= bus.mem_out;
        end
      end

      if (abort) bus.bus_error <= 1'b1;

      if (!bus.if_req || grant_if)               dm_streak <= '0;
      else if (grant_dm && dm_streak != STREAK_MAX) dm_streak <= dm_streak + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model of the
// requesters, the arbitration rules and a memory array.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem_m [4096];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.mem_out  = '0;
    bus.mem_ack  = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.mem_enable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    int          n;
    bit          want_if;
    // random-phase model state
    int          owner;       // 0 none, 1 IF, 2 DM
    int          lat;
    int          streak;
    bit          ifp, dmp, dwe, cur_we;
    logic [9:0]  pc;
    logic [11:0] da, exp_addr;
    logic [31:0] dwd, cur_wd, exp_if_data, exp_dm_data;
    bit          exp_if_rdy, exp_dm_rdy, exp_dm_load, vis_if, vis_dm;

    // ---- reset then idle, spurious ack ignored
    reset = 1'b1;
    idle_inputs();
    tick;
    tick;
    reset = 1'b0;
    tick;
    check1("rst_mem_enable", bus.mem_enable, 1'b0);
    check1("rst_mem_read",   bus.mem_read,   1'b0);
    check1("rst_mem_write",  bus.mem_write,  1'b0);
    check ("rst_mem_address", 32'(bus.mem_address), 32'h0);
    check ("rst_mem_in",     bus.mem_in,     32'h0);
    check ("rst_if_rdata",   bus.if_rdata,   32'h0);
    check ("rst_dm_rdata",   bus.dm_rdata,   32'h0);
    check1("rst_bus_error",  bus.bus_error,  1'b0);
    check1("rst_stall",      bus.stall_pipeline, 1'b0);
    bus.mem_ack = 1'b1;
    bus.mem_out = 32'hFFFF_FFFF;
    tick;
    check1("spur_if_ready", bus.if_ready, 1'b0);
    check1("spur_dm_ready", bus.dm_ready, 1'b0);
    check1("spur_enable",   bus.mem_enable, 1'b0);
    bus.mem_ack = 1'b0;

    // ---- IF only, ack on the second busy cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h004;
    #1;
    check1("if_stall_req", bus.stall_pipeline, 1'b1);
    tick;
    check1("if_enable",  bus.mem_enable, 1'b1);
    check1("if_read",    bus.mem_read,   1'b1);
    check1("if_write",   bus.mem_write,  1'b0);
    check ("if_address", 32'(bus.mem_address), 32'h0000_0C04);
    tick;
    bus.mem_ack = 1'b1;
    bus.mem_out = 32'h1234_5678;
    tick;
    check1("if_ready_pulse", bus.if_ready, 1'b1);
    check ("if_rdata",       bus.if_rdata, 32'h1234_5678);
    check1("if_read_drop",   bus.mem_read, 1'b0);
    check1("if_enable_drop", bus.mem_enable, 1'b0);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick;
    check1("if_ready_once", bus.if_ready, 1'b0);

    // ---- simultaneous IF + DM load: DM first, then IF
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h020;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'h010;
    tick;
    check ("both_dm_addr", 32'(bus.mem_address), 32'h0000_0010);
    check1("both_dm_read", bus.mem_read, 1'b1);
    check1("both_stall",   bus.stall_pipeline, 1'b1);
    bus.mem_ack = 1'b1;
    bus.mem_out = 32'hAAAA_5555;
    tick;
    check1("both_dm_ready", bus.dm_ready, 1'b1);
    check1("both_if_notyet", bus.if_ready, 1'b0);
    check ("both_dm_rdata", bus.dm_rdata, 32'hAAAA_5555);
    bus.mem_ack = 1'b0;
    bus.dm_req  = 1'b0;
    #1;
    check1("both_stall_if_wait", bus.stall_pipeline, 1'b1);
    wait_grant(ok);
    check1("both_if_grant_found", ok, 1'b1);
    check ("both_if_addr", 32'(bus.mem_address), 32'h0000_0C20);
    check1("both_if_read", bus.mem_read, 1'b1);
    bus.mem_ack = 1'b1;
    bus.mem_out = 32'h0BAD_F00D;
    tick;
    check1("both_if_ready", bus.if_ready, 1'b1);
    check ("both_if_rdata", bus.if_rdata, 32'h0BAD_F00D);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    #1;
    check1("both_stall_clear", bus.stall_pipeline, 1'b0);

    // ---- DM store streak with IF waiting: D D D D I D
    bus.if_req   = 1'b1;
    bus.if_addr  = 10'h030;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 12'h100;
    bus.dm_wdata = 32'hDEAD_0000;
    for (int g = 0; g < 6; g++) begin
      wait_grant(ok);
      check1("streak_grant_found", ok, 1'b1);
      want_if = (g == 4);
      check1("streak_is_if_read", bus.mem_read,  want_if);
      check1("streak_is_dm_write", bus.mem_write, !want_if);
      check ("streak_addr", 32'(bus.mem_address), want_if ? 32'h0000_0C30 : 32'h0000_0100);
      if (!want_if) check("streak_mem_in", bus.mem_in, bus.dm_wdata);
      bus.mem_ack = 1'b1;
      tick;
      bus.mem_ack = 1'b0;
      check1("streak_ready", want_if ? bus.if_ready : bus.dm_ready, 1'b1);
      bus.dm_wdata = 32'hDEAD_0001 + 32'(g);
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick;
    tick;

    // ---- DM load timeout
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 12'h055;
    tick;
    check1("tmo_grant",  bus.mem_enable, 1'b1);
    check ("tmo_addr",   32'(bus.mem_address), 32'h0000_0055);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (bus.dm_ready) begin
        n = i;
        break;
      end
    end
    check ("tmo_latency",  n, 15);
    check ("tmo_rdata",    bus.dm_rdata, 32'h0);
    check1("tmo_bus_error", bus.bus_error, 1'b1);
    check1("tmo_enable_drop", bus.mem_enable, 1'b0);
    check1("tmo_read_drop",   bus.mem_read,   1'b0);
    bus.dm_req  = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h3FF;
    wait_grant(ok);
    check1("post_tmo_grant_found", ok, 1'b1);
    check ("post_tmo_addr", 32'(bus.mem_address), 32'h0000_0FFF);
    bus.mem_ack = 1'b1;
    bus.mem_out = 32'hCAFE_BABE;
    tick;
    check1("post_tmo_if_ready", bus.if_ready, 1'b1);
    check ("post_tmo_if_rdata", bus.if_rdata, 32'hCAFE_BABE);
    check1("post_tmo_sticky",   bus.bus_error, 1'b1);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick;

    // ---- reset during a DM store
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 12'h077;
    bus.dm_wdata = 32'h7777_0000;
    tick;
    check1("rstmid_write", bus.mem_write, 1'b1);
    check ("rstmid_mem_in", bus.mem_in, 32'h7777_0000);
    reset = 1'b1;
    tick;
    check1("rstmid_write_drop",  bus.mem_write,  1'b0);
    check1("rstmid_enable_drop", bus.mem_enable, 1'b0);
    check1("rstmid_no_ready",    bus.dm_ready,   1'b0);
    check1("rstmid_err_clear",   bus.bus_error,  1'b0);
    reset       = 1'b0;
    bus.dm_req  = 1'b0;
    bus.mem_ack = 1'b1;
    tick;
    check1("rstmid_late_ack_dm", bus.dm_ready,   1'b0);
    check1("rstmid_late_ack_en", bus.mem_enable, 1'b0);
    bus.mem_ack = 1'b0;
    tick;
    check1("rstmid_still_idle", bus.dm_ready, 1'b0);

    // ---- randomized traffic against the transaction model
    reset = 1'b1;
    idle_inputs();
    tick;
    reset = 1'b0;
    for (int a = 0; a < 4096; a++) mem_m[a] = $urandom;
    owner = 0; lat = 0; streak = 0; ifp = 0; dmp = 0;
    cur_we = 0; cur_wd = '0; exp_addr = '0; pc = '0; da = '0; dwd = '0; dwe = 0;
    exp_if_rdy = 0; exp_dm_rdy = 0; exp_dm_load = 0; exp_if_data = '0; exp_dm_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick;
      check1("rnd_if_ready", bus.if_ready, exp_if_rdy);
      check1("rnd_dm_ready", bus.dm_ready, exp_dm_rdy);
      if (exp_if_rdy) check("rnd_if_rdata", bus.if_rdata, exp_if_data);
      if (exp_dm_rdy && exp_dm_load) check("rnd_dm_rdata", bus.dm_rdata, exp_dm_data);
      check1("rnd_enable", bus.mem_enable, owner != 0);
      if (owner != 0) begin
        check ("rnd_addr",  32'(bus.mem_address), 32'(exp_addr));
        check1("rnd_read",  bus.mem_read,  !(owner == 2 && cur_we));
        check1("rnd_write", bus.mem_write, owner == 2 && cur_we);
        if (owner == 2 && cur_we) check("rnd_mem_in", bus.mem_in, cur_wd);
      end

      vis_if = exp_if_rdy;
      vis_dm = exp_dm_rdy;
      if (vis_if) ifp = 1'b0;
      if (vis_dm) dmp = 1'b0;
      if (!ifp && $urandom_range(0, 2) == 0) begin
        ifp = 1'b1;
        pc  = 10'($urandom);
      end
      if (!dmp && $urandom_range(0, 2) == 0) begin
        dmp = 1'b1;
        dwe = 1'($urandom);
        da  = 12'($urandom);
        dwd = $urandom;
      end
      bus.if_req   = ifp;
      bus.if_addr  = pc;
      bus.dm_req   = dmp;
      bus.dm_we    = dwe;
      bus.dm_addr  = da;
      bus.dm_wdata = dwd;

      exp_if_rdy  = 1'b0;
      exp_dm_rdy  = 1'b0;
      bus.mem_ack = 1'b0;
      bus.mem_out = $urandom;
      if (owner != 0) begin
        if (lat == 0) begin
          bus.mem_ack = 1'b1;
          if (!(owner == 2 && cur_we)) bus.mem_out = mem_m[exp_addr];
          if (owner == 1) begin
            exp_if_rdy  = 1'b1;
            exp_if_data = mem_m[exp_addr];
          end else begin
            exp_dm_rdy  = 1'b1;
            exp_dm_load = !cur_we;
            exp_dm_data = mem_m[exp_addr];
            if (cur_we) mem_m[exp_addr] = cur_wd;
          end
          owner = 0;
        end else begin
          lat--;
        end
      end else begin
        bus.mem_ack = ($urandom_range(0, 3) == 0);
        if (!vis_if && !vis_dm && (ifp || dmp)) begin
          if (ifp && (!dmp || streak == 4)) begin
            owner    = 1;
            exp_addr = 12'hC00 | {2'b00, pc};
            streak   = 0;
          end else begin
            owner    = 2;
            exp_addr = da;
            cur_we   = dwe;
            cur_wd   = dwd;
            if (streak < 4) streak++;
          end
          lat = $urandom_range(0, 4);
        end
      end
      if (!ifp) streak = 0;
      #1;
      check1("rnd_stall", bus.stall_pipeline, (ifp && !vis_if) || (dmp && !vis_dm));
    end
    check1("rnd_no_bus_error", bus.bus_error, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
